// File: rtl/tff_pkg.sv
// Shared mode encodings and small helpers for the T-flip-flop counter family.
package tff_pkg;

  typedef enum logic [1:0] {
    TFF_TOGGLE = 2'b00,
    TFF_UP     = 2'b01,
    TFF_DOWN   = 2'b10,
    TFF_HOLD   = 2'b11
  } tff_mode_t;

  // Terminal count: sitting at the limit the current direction would cross.
  function automatic logic tff_at_limit(input tff_mode_t mode, input logic at_max,
                                        input logic at_min);
    return ((mode == TFF_UP) && at_max) || ((mode == TFF_DOWN) && at_min);
  endfunction

endpackage

// File: rtl/tff_counter_if.sv
// Control/status bundle between a counter user (master) and tff_counter (slave).
interface tff_counter_if
  import tff_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             ld;
  tff_mode_t        mode;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;
  logic             wrap;

  modport master (
    output en, ld, mode, t_vec, d,
    input  q, q_bar, tc, wrap
  );

  modport slave (
    input  en, ld, mode, t_vec, d,
    output q, q_bar, tc, wrap
  );

endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low reset to a per-cell value.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic rst_val,
  output logic q,
  output logic q_bar
);

  logic q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)   q_q <= rst_val;
    else if (t) q_q <= ~q_q;
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/tff_counter.sv
// Loadable up/down/toggle counter whose every update is a set of per-cell toggle
// enables driving WIDTH T flip-flops; optional saturation, tc and wrap flags.
module tff_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input logic          clk,
  input logic          rst,
  tff_counter_if.slave bus
);

  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] q, q_bar;
  logic [WIDTH-1:0] t_up, t_dn, t_sel, t_en;
  logic             at_max, at_min, tc, limit_edge;
  logic             wrap_q, wrap_d;

  // Ripple enables: a cell flips once every lower cell is 1 (up) or 0 (down).
  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign t_up[i] = t_up[i-1] &  q[i-1];
    assign t_dn[i] = t_dn[i-1] & ~q[i-1];
  end

  assign at_max = &q;
  assign at_min = ~|q;
  assign tc     = tff_at_limit(bus.mode, at_max, at_min);

  always_comb begin
    t_sel = '0;
    if (bus.ld) begin
      t_sel = q ^ bus.d;
    end else if (bus.en) begin
      unique case (bus.mode)
        TFF_TOGGLE: t_sel = bus.t_vec;
        TFF_UP:     t_sel = t_up;
        TFF_DOWN:   t_sel = t_dn;
        default:    t_sel = '0;
      endcase
    end
  end

  // tc only rises in UP/DOWN, so this is exactly a count edge crossing a limit.
  assign limit_edge = bus.en & ~bus.ld & tc;
  assign t_en       = (SAT && limit_edge) ? '0 : t_sel;
  assign wrap_d     = limit_edge & ~SAT;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .t       (t_en[i]),
      .rst_val (RST_VAL[i]),
      .q       (q[i]),
      .q_bar   (q_bar[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  assign bus.q     = q;
  assign bus.q_bar = q_bar;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap_q;

endmodule
